pipe_stage_chain: RTL

//   DEPTH-stage pipeline register chain with per-stage valid, stall and flush.

---
 rtl/pipe_stage_chain_if.sv | 28 ++
 rtl/pipe_stage_chain.sv | 94 +++++++++
 2 files changed

// File: rtl/pipe_stage_chain_if.sv
// Handshake and control bundle for pipe_stage_chain.
// The producer/hazard side uses the master modport; the pipeline uses the slave modport.
interface pipe_stage_chain_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 3,
  parameter int CNT_W = 16
);
  logic                 in_valid;
  logic [WIDTH-1:0]     in_data;
  logic                 in_ready;
  logic [DEPTH-1:0]     stall;
  logic [DEPTH-1:0]     flush;
  logic [DEPTH-1:0]     stage_valid;
  logic                 out_valid;
  logic [WIDTH-1:0]     out_data;
  logic [CNT_W-1:0]     stall_cnt;
  logic [CNT_W-1:0]     kill_cnt;

  modport master (
    output in_valid, in_data, stall, flush,
    input  in_ready, stage_valid, out_valid, out_data, stall_cnt, kill_cnt
  );

  modport slave (
    input  in_valid, in_data, stall, flush,
    output in_ready, stage_valid, out_valid, out_data, stall_cnt, kill_cnt
  );
endinterface

// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: DEPTH-stage pipeline register chain with per-stage valid,
// stall and flush. Stage 0 is the input side, stage DEPTH-1 drives out_*.
// A stall freezes its stage and every stage upstream of it; the first stage
// below a frozen region receives a bubble (valid=0, data=0) so downstream
// decode sees a NOP. Flush clears a stage and wins over stall.
// Optional feature macro: PIPE_PERF_CNT_EN builds saturating stall/kill
// performance counters; without it stall_cnt/kill_cnt are tied to zero.
module pipe_stage_chain #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 3,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  pipe_stage_chain_if.slave   bus
);

  logic [DEPTH-1:0]            w_hold;
  logic [DEPTH-1:0]            r_valid;
  logic [DEPTH-1:0][WIDTH-1:0] r_data;

  // Hold for stage i is any stall at stage i or further downstream.
  always_comb begin
    w_hold = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_hold[i] = |(bus.stall >> i);
    end
  end

  // Stage registers: reset, flush, hold, bubble, then load, in that priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
      r_data  <= '0;
    end else begin
      if (bus.flush[0]) begin
        r_valid[0] <= 1'b0;
        r_data[0]  <= '0;
      end else if (!w_hold[0]) begin
        // Data is captured even when in_valid=0; it is don't-care then.
        r_valid[0] <= bus.in_valid;
        r_data[0]  <= bus.in_data;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (bus.flush[i]) begin
          r_valid[i] <= 1'b0;
          r_data[i]  <= '0;
        end else if (!w_hold[i]) begin
          if (w_hold[i-1]) begin
            r_valid[i] <= 1'b0;
            r_data[i]  <= '0;
          end else begin
            r_valid[i] <= r_valid[i-1];
            r_data[i]  <= r_data[i-1];
          end
        end
      end
    end
  end

  assign bus.in_ready    = ~w_hold[0];
  assign bus.stage_valid = r_valid;
  assign bus.out_valid   = r_valid[DEPTH-1];
  assign bus.out_data    = r_data[DEPTH-1];

`ifdef PIPE_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_kill_cnt;

  // Saturating counters: cycles with any stall, cycles where a flush hits a valid stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_kill_cnt  <= '0;
    end else begin
      if ((|bus.stall) && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
      end
      if ((|(bus.flush & r_valid)) && (r_kill_cnt != '1)) begin
        r_kill_cnt <= r_kill_cnt + CNT_ONE;
      end
    end
  end

  assign bus.stall_cnt = r_stall_cnt;
  assign bus.kill_cnt  = r_kill_cnt;
`else
  assign bus.stall_cnt = '0;
  assign bus.kill_cnt  = '0;
`endif

endmodule
